// File: rtl/game_tick_ctrl.sv
// game_tick_ctrl
//   Central timing controller for the snake game. Everything runs on the
//   single 100 MHz clock. A registered pixel-enable strobe replaces the old
//   ripple-divided pixel clock. Game-logic steps are scheduled every P VGA
//   frames, where P depends on the speed level. Each step is handed to the
//   game logic through a req/ack handshake. If a step comes due while the
//   previous one is still pending, the controller flags an overrun and counts
//   it. Pause and single-step are provided for debug.
//
// Ports
//   clock100      in   system clock; all logic uses its rising edge
//   reset_n       in   asynchronous reset, active low
//   pix_en        out  one-cycle pixel-enable strobe, once every PIX_DIV cycles
//   frame_start   in   one-cycle pulse at the start of each VGA frame
//   speed         in   game speed level; P = FRAMES_MAX - speed (minimum 1)
//   pause         in   level; freezes step scheduling
//   single_step   in   pulse; issues one step while paused and idle
//   step_req      out  step request, held until step_ack
//   step_ack      in   one-cycle acknowledge from game logic
//   overrun       out  sticky: a step came due while one was still pending
//   missed_cnt    out  saturating count of overrun events
//   clear_overrun in   pulse; clears overrun and missed_cnt
module game_tick_ctrl #(
  parameter int unsigned PIX_DIV    = 4,
  parameter int unsigned SPEED_W    = 3,
  parameter int unsigned FRAMES_MAX = 8,
  parameter int unsigned MISS_W     = 4
) (
  input  logic               clock100,
  input  logic               reset_n,
  output logic               pix_en,
  input  logic               frame_start,
  input  logic [SPEED_W-1:0] speed,
  input  logic               pause,
  input  logic               single_step,
  output logic               step_req,
  input  logic               step_ack,
  output logic               overrun,
  output logic [MISS_W-1:0]  missed_cnt,
  input  logic               clear_overrun
);

  localparam int unsigned PIX_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int unsigned FC_W  = (FRAMES_MAX > 1) ? $clog2(FRAMES_MAX) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_DIV - 1);

  typedef enum logic {RUN, PAUSED} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_run;

  logic [PIX_W-1:0]   r_pix_cnt;
  logic               r_pix_en;
  logic [FC_W-1:0]    r_fc;
  logic               r_step_req;
  logic               r_overrun;
  logic [MISS_W-1:0]  r_missed;

  logic [31:0]        w_speed;
  logic [31:0]        w_pm1;
  logic               w_due;
  logic               w_ss_go;
  logic               w_ovr_ev;

  // Pixel enable: free-running divider. The strobe is registered, so the
  // first pulse appears after the PIX_DIV-th edge following reset release.
  always_ff @(posedge clock100 or negedge reset_n) begin
    if (!reset_n) begin
      r_pix_cnt <= '0;
      r_pix_en  <= 1'b0;
    end else if (r_pix_cnt == PIX_LAST) begin
      r_pix_cnt <= '0;
      r_pix_en  <= 1'b1;
    end else begin
      r_pix_cnt <= r_pix_cnt + 1'b1;
      r_pix_en  <= 1'b0;
    end
  end

  // Run/pause FSM: state register
  always_ff @(posedge clock100 or negedge reset_n) begin
    if (!reset_n) r_state <= RUN;
    else          r_state <= w_state_nxt;
  end

  // Run/pause FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    if (pause) w_state_nxt = PAUSED;
    else       w_state_nxt = RUN;
  end

  // Run/pause FSM: outputs
  always_comb begin
    w_run = 1'b0;
    if (r_state == RUN) w_run = 1'b1;
  end

  // Step period minus one. Speeds at or beyond FRAMES_MAX clamp to P = 1.
  always_comb begin
    w_speed = 32'(speed);
    w_pm1   = '0;
    if (w_speed < FRAMES_MAX) w_pm1 = FRAMES_MAX - 32'd1 - w_speed;
  end

  // The >= comparison lets a speed-up mid-period fire on the next frame
  // instead of waiting for the counter to wrap.
  assign w_due    = w_run & frame_start & (32'(r_fc) >= w_pm1);
  assign w_ss_go  = ~w_run & single_step & ~r_step_req;
  assign w_ovr_ev = w_due & r_step_req & ~step_ack;

  // Frame counter advances only while running and holds its value in pause
  always_ff @(posedge clock100 or negedge reset_n) begin
    if (!reset_n) begin
      r_fc <= '0;
    end else if (w_run && frame_start) begin
      if (w_due) r_fc <= '0;
      else       r_fc <= r_fc + 1'b1;
    end
  end

  // A due step coinciding with an ack consumes the old request and issues the
  // new one, so the due/single-step term takes priority over the ack.
  always_ff @(posedge clock100 or negedge reset_n) begin
    if (!reset_n) begin
      r_step_req <= 1'b0;
    end else if (w_due || w_ss_go) begin
      r_step_req <= 1'b1;
    end else if (step_ack) begin
      r_step_req <= 1'b0;
    end
  end

  // Overrun bookkeeping. An event in the same cycle as a clear wins, and the
  // count restarts at one.
  always_ff @(posedge clock100 or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun <= 1'b0;
      r_missed  <= '0;
    end else if (w_ovr_ev) begin
      r_overrun <= 1'b1;
      if (clear_overrun)       r_missed <= MISS_W'(1);
      else if (r_missed != '1) r_missed <= r_missed + 1'b1;
    end else if (clear_overrun) begin
      r_overrun <= 1'b0;
      r_missed  <= '0;
    end
  end

  assign pix_en     = r_pix_en;
  assign step_req   = r_step_req;
  assign overrun    = r_overrun;
  assign missed_cnt = r_missed;

endmodule
